// File: rtl/dsp_slice_pkg.sv
// dsp_slice_pkg: shared pre-adder mode encodings and saturation-limit helper for the DSP slice
//   PA_BYP/PA_ADD/PA_SUB/PA_RSUB : pre-adder modes (A, A+B, A-B, B-A)
//   sat_lim(w, neg)              : most-negative (neg=1) or most-positive signed value of width w
package dsp_slice_pkg;
   typedef enum logic [1:0] {PA_BYP = 2'b00, PA_ADD = 2'b01, PA_SUB = 2'b10, PA_RSUB = 2'b11} pa_mode_e;
   localparam int LIM_W = 128;
   function automatic logic signed [LIM_W-1:0] sat_lim(input int w, input logic neg);
      logic signed [LIM_W-1:0] one;
      one = LIM_W'(1);
      return neg ? -(one <<< (w - 1)) : (one <<< (w - 1)) - one;
   endfunction
endpackage

// File: rtl/dsp_coef_bank.sv
// dsp_coef_bank: NCOEF x C_W coefficient register file, one sync write port, one async read port
//   clk, clr_n       : clock, async active-low reset (clears every entry)
//   we/waddr/wdata   : write strobe, index, data
//   raddr/rdata      : read index, combinational read data
module dsp_coef_bank #(
   parameter int C_W = 27,
   parameter int NCOEF = 8,
   localparam int CS_W = $clog2(NCOEF)
) (
   input  logic                   clk,
   input  logic                   clr_n,
   input  logic                   we,
   input  logic [CS_W-1:0]        waddr,
   input  logic signed [C_W-1:0]  wdata,
   input  logic [CS_W-1:0]        raddr,
   output logic signed [C_W-1:0]  rdata
);
   logic signed [C_W-1:0] mem [NCOEF];
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n)
         for (int i = 0; i < NCOEF; i++) mem[i] <= '0;
      else if (we)
         mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/dsp_slice_param.sv
// dsp_slice_param: 4-stage pre-add / multiply / negate / accumulate DSP slice with coef bank and saturation
//   clk, clr_n          : clock, async active-low reset
//   ena, in_valid       : pipeline enable, beat valid
//   pa_mode..coefsel    : per-beat controls, travel with their operands
//   ay, az, ax          : pre-adder operands, direct multiplicand
//   coef_we/waddr/wdata : coefficient bank write (independent of ena)
//   constant, chainin   : accumulator seed, cascade input
//   ovf_clr             : clears sticky ovf
//   out_valid, resulta, chainout, ovf : result pulse, result, cascade out, sticky overflow
module dsp_slice_param
   import dsp_slice_pkg::*;
#(
   parameter int A_W = 27,
   parameter int B_W = 26,
   parameter int C_W = 27,
   parameter int ACC_W = 64,
   parameter int NCOEF = 8,
   parameter int SAT_EN = 1,
   localparam int CS_W = $clog2(NCOEF)
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              ena,
   input  logic              in_valid,
   input  logic [1:0]        pa_mode,
   input  logic              negate,
   input  logic              accumulate,
   input  logic              loadconst,
   input  logic              chain_en,
   input  logic              use_coef,
   input  logic [A_W-1:0]    ay,
   input  logic [B_W-1:0]    az,
   input  logic [C_W-1:0]    ax,
   input  logic [CS_W-1:0]   coefsel,
   input  logic              coef_we,
   input  logic [CS_W-1:0]   coef_waddr,
   input  logic [C_W-1:0]    coef_wdata,
   input  logic [ACC_W-1:0]  constant,
   input  logic [ACC_W-1:0]  chainin,
   input  logic              ovf_clr,
   output logic              out_valid,
   output logic [ACC_W-1:0]  resulta,
   output logic [ACC_W-1:0]  chainout,
   output logic              ovf
);
   localparam int PA_W = (A_W > B_W ? A_W : B_W) + 1;
   localparam int PW = PA_W + C_W;
   // two guard bits: base + product + chainin can exceed ACC_W+1 bits
   localparam int SW = ACC_W + 2;
   localparam logic signed [SW-1:0] SMAX = SW'(sat_lim(ACC_W, 1'b0));
   localparam logic signed [SW-1:0] SMIN = SW'(sat_lim(ACC_W, 1'b1));
   logic              v0, neg0, acc0, ld0, ch0, uc0;
   pa_mode_e          pm0;
   logic [A_W-1:0]    ay0;
   logic [B_W-1:0]    az0;
   logic [C_W-1:0]    ax0;
   logic [CS_W-1:0]   cs0;
   logic [ACC_W-1:0]  k0, ci0, k1, ci1, k2, ci2;
   logic              v1, neg1, acc1, ld1, ch1, v2, acc2, ld2, ch2;
   logic signed [PA_W-1:0] ya, za, pa_n, pa1;
   logic signed [C_W-1:0]  coef_rd, m1;
   logic signed [PW-1:0]   mul, p2;
   logic signed [SW-1:0]   sum;
   logic [SW-1:0]          base, chn;
   logic                   ovr;
   logic [ACC_W-1:0]       res_n;
   dsp_coef_bank #(.C_W(C_W), .NCOEF(NCOEF)) u_coef (
      .clk(clk), .clr_n(clr_n), .we(coef_we), .waddr(coef_waddr), .wdata(coef_wdata),
      .raddr(cs0), .rdata(coef_rd)
   );
   assign ya = $signed({{(PA_W-A_W){ay0[A_W-1]}}, ay0});
   assign za = $signed({{(PA_W-B_W){az0[B_W-1]}}, az0});
   assign pa_n = pm0 == PA_ADD ? ya + za : pm0 == PA_SUB ? ya - za : pm0 == PA_RSUB ? za - ya : ya;
   // the exact product fits PW bits, so the truncated PW x PW product is exact
   assign mul = $signed({{C_W{pa1[PA_W-1]}}, pa1}) * $signed({{PA_W{m1[C_W-1]}}, m1});
   assign base = ld2 ? {{2{k2[ACC_W-1]}}, k2} : acc2 ? {{2{resulta[ACC_W-1]}}, resulta} : '0;
   assign chn = ch2 ? {{2{ci2[ACC_W-1]}}, ci2} : '0;
   assign sum = $signed(base + {{(SW-PW){p2[PW-1]}}, p2} + chn);
   assign ovr = sum > SMAX || sum < SMIN;
   assign res_n = ovr && SAT_EN != 0 ? (sum[SW-1] ? SMIN[ACC_W-1:0] : SMAX[ACC_W-1:0]) : sum[ACC_W-1:0];
   assign chainout = resulta;
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) begin
         {v0, neg0, acc0, ld0, ch0, uc0} <= '0;
         pm0 <= PA_BYP;
         {ay0, az0, ax0, cs0, k0, ci0} <= '0;
         {v1, neg1, acc1, ld1, ch1, pa1, m1, k1, ci1} <= '0;
         {v2, acc2, ld2, ch2, p2, k2, ci2} <= '0;
         {out_valid, resulta, ovf} <= '0;
      end else begin
         if (ena) begin
            {v0, neg0, acc0, ld0, ch0, uc0} <= {in_valid, negate, accumulate, loadconst, chain_en, use_coef};
            pm0 <= pa_mode_e'(pa_mode);
            {ay0, az0, ax0, cs0, k0, ci0} <= {ay, az, ax, coefsel, constant, chainin};
            {v1, neg1, acc1, ld1, ch1, k1, ci1} <= {v0, neg0, acc0, ld0, ch0, k0, ci0};
            pa1 <= pa_n;
            m1 <= uc0 ? coef_rd : $signed(ax0);
            {v2, acc2, ld2, ch2, k2, ci2} <= {v1, acc1, ld1, ch1, k1, ci1};
            p2 <= neg1 ? -mul : mul;
            if (v2) resulta <= res_n;
         end
         out_valid <= ena && v2;
         // a new overflow beats a simultaneous clear
         ovf <= (ovf && !ovf_clr) || (ena && v2 && ovr);
      end
endmodule
